dma_rd_burst_sched: RTL and testbench

//  Read-side burst scheduler for the DMA datapath. It takes one transfer descriptor (start address and byte length)
//  and splits it into AXI read address bursts. Each burst is no longer than MAX_BURST beats and never crosses a
//  4KB boundary. A burst is issued only when the downstream dma_fifo has room for every beat already in flight

---
 rtl/dma_rd_burst_sched.sv | 150 +++++++++++++++
 tb/tb_dma_rd_burst_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_rd_burst_sched.sv
// Read-side DMA burst scheduler: splits one descriptor into AXI AR bursts
// that respect MAX_BURST, 4KB boundaries and downstream FIFO room.
module dma_rd_burst_sched #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int LEN_W      = 24,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 64,
    parameter int MAX_OUTST  = 4,
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              abort,
    input  logic [CNT_W-1:0]  fifo_free_cnt,
    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [ADDR_W-1:0] ar_addr,
    output logic [7:0]        ar_len,
    input  logic              r_beat,
    input  logic              r_last,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              err
);

    localparam int BPB   = DATA_W / 8;
    localparam int OFS   = $clog2(BPB);
    localparam int OUT_W = $clog2(MAX_OUTST + 1);

    typedef enum logic [2:0] {IDLE, CALC, ISSUE, DRAIN, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  rem;
    logic [8:0]        burst;
    logic [CNT_W-1:0]  rsv;
    logic [OUT_W-1:0]  outst;
    logic              abort_pend;

    logic [12:0] room;
    logic [8:0]  burst_c;
    logic [9:0]  need;
    logic        fits;
    logic        hs;
    logic        dec_r;
    logic        dec_o;

    // Beats left before the next 4KB page, capped by MAX_BURST and rem.
    always_comb begin
        room    = (13'd4096 - {1'b0, addr[11:0]}) >> OFS;
        burst_c = 9'(MAX_BURST);
        if (rem < LEN_W'(burst_c)) burst_c = rem[8:0];
        if (room < 13'(burst_c)) burst_c = room[8:0];
        need = 10'(rsv) + 10'(burst_c);
        fits = (10'(fifo_free_cnt) >= need) && (outst < OUT_W'(MAX_OUTST));
    end

    assign hs    = ar_valid & ar_ready;
    assign dec_r = r_beat & (rsv != '0);
    assign dec_o = r_beat & r_last & (outst != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cfg_ready  <= 1'b1;
            ar_valid   <= 1'b0;
            ar_addr    <= '0;
            ar_len     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            err        <= 1'b0;
            addr       <= '0;
            rem        <= '0;
            burst      <= '0;
            rsv        <= '0;
            outst      <= '0;
            abort_pend <= 1'b0;
        end else begin
            rsv   <= rsv + (hs ? CNT_W'(burst) : '0) - CNT_W'(dec_r);
            outst <= outst + OUT_W'(hs) - OUT_W'(dec_o);
            if (r_beat && rsv == '0) err <= 1'b1;
            done    <= 1'b0;
            aborted <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        cfg_ready  <= 1'b0;
                        busy       <= 1'b1;
                        addr       <= cfg_addr;
                        rem        <= cfg_len >> OFS;
                        err        <= r_beat && rsv == '0;
                        abort_pend <= 1'b0;
                        if ((cfg_len >> OFS) == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (abort) begin
                        abort_pend <= 1'b1;
                        state      <= DRAIN;
                    end else if (fits) begin
                        burst    <= burst_c;
                        ar_valid <= 1'b1;
                        ar_addr  <= addr;
                        ar_len   <= 8'(burst_c - 9'd1);
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (abort) abort_pend <= 1'b1;
                    if (ar_ready) begin
                        ar_valid <= 1'b0;
                        addr     <= addr + (ADDR_W'(burst) << OFS);
                        rem      <= rem - LEN_W'(burst);
                        if (rem != LEN_W'(burst) && !abort && !abort_pend)
                            state <= CALC;
                        else
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (rsv == '0 && outst == '0) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        aborted <= abort_pend;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    cfg_ready  <= 1'b1;
                    abort_pend <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_rd_burst_sched.sv
// Bench for dma_rd_burst_sched: directed cases plus randomized descriptors
// checked against a queue model of bursts and in-flight beats.
module tb_dma_rd_burst_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_addr;
    logic [23:0] cfg_len;
    logic        abort;
    logic [6:0]  fifo_free_cnt;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic        r_beat;
    logic        r_last;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        err;

    dma_rd_burst_sched u_dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr), .cfg_len(cfg_len),
        .abort(abort), .fifo_free_cnt(fifo_free_cnt),
        .ar_valid(ar_valid), .ar_ready(ar_ready),
        .ar_addr(ar_addr), .ar_len(ar_len),
        .r_beat(r_beat), .r_last(r_last),
        .busy(busy), .done(done), .aborted(aborted), .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_a[$];
    int          exp_b[$];
    int          rq[$];
    logic [6:0]  cur_free;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference split: page room, MAX_BURST and remaining beats, 8 bytes/beat.
    task automatic build_model(input logic [31:0] a, input logic [23:0] l);
        int r;
        int b;
        int room;
        logic [31:0] cur;
        exp_a.delete();
        exp_b.delete();
        rq.delete();
        cur = a;
        r = int'(l) / 8;
        while (r > 0) begin
            room = (4096 - int'(cur % 4096)) / 8;
            b = 16;
            if (r < b) b = r;
            if (room < b) b = room;
            exp_a.push_back(cur);
            exp_b.push_back(b);
            cur = cur + 32'(b * 8);
            r = r - b;
        end
    endtask

    task automatic start_xfer(input logic [31:0] a, input logic [23:0] l,
                              input logic [6:0] f);
        check("cfg_ready_idle", cfg_ready, 1);
        build_model(a, l);
        cfg_valid = 1'b1;
        cfg_addr = a;
        cfg_len = l;
        fifo_free_cnt = f;
        cur_free = f;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("busy_after_accept", busy, 1);
        check("cfg_ready_after_accept", cfg_ready, 0);
        check("err_cleared_on_accept", err, 0);
    endtask

    task automatic run_until_done(input int rdy_pct, input int r_pct,
                                  input int abort_cyc, output int cycles);
        bit aborted_mode = 0;
        bit pend_ok = 0;
        int resv;
        int outn;
        bit fin = 0;
        cycles = -1;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (done) begin
                cycles = cyc;
                check("done_rq_empty", rq.size(), 0);
                check("done_aborted", aborted, aborted_mode);
                if (!aborted_mode) check("done_all_ar", exp_a.size(), 0);
                r_beat = 1'b0; r_last = 1'b0; abort = 1'b0; ar_ready = 1'b0;
                @(negedge clk);
                check("done_pulse_1cyc", done, 0);
                check("idle_busy", busy, 0);
                check("idle_cfg_ready", cfg_ready, 1);
                fin = 1;
            end else begin
                if (aborted_mode) check("no_new_ar_after_abort", ar_valid & ~pend_ok, 0);
                resv = 0;
                foreach (rq[i]) resv += rq[i];
                outn = rq.size();
                r_beat = 1'b0;
                r_last = 1'b0;
                if (rq.size() > 0 && $urandom_range(99) < r_pct) begin
                    r_beat = 1'b1;
                    rq[0] = rq[0] - 1;
                    if (rq[0] == 0) begin
                        r_last = 1'b1;
                        void'(rq.pop_front());
                    end
                end
                abort = 1'b0;
                if (cyc == abort_cyc && exp_a.size() > (ar_valid ? 1 : 0)) begin
                    abort = 1'b1;
                    aborted_mode = 1;
                    pend_ok = ar_valid;
                end
                ar_ready = ($urandom_range(99) < rdy_pct);
                if (ar_valid && ar_ready) begin
                    check("ar_expected", exp_a.size() != 0, 1);
                    if (exp_a.size() != 0) begin
                        check("ar_addr", ar_addr, exp_a[0]);
                        check("ar_len", ar_len, exp_b[0] - 1);
                        check("fifo_room", resv + exp_b[0] <= int'(cur_free), 1);
                        check("max_outst", outn + 1 <= 4, 1);
                        rq.push_back(exp_b[0]);
                        void'(exp_a.pop_front());
                        void'(exp_b.pop_front());
                    end
                    pend_ok = 0;
                end
                @(negedge clk);
            end
        end
        if (!fin) check("done_timeout", done, 1);
        r_beat = 1'b0; r_last = 1'b0; abort = 1'b0; ar_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [31:0] tmp;
        logic [31:0] a;
        rst = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_len = '0;
        abort = 1'b0; fifo_free_cnt = '0; ar_ready = 1'b0;
        r_beat = 1'b0; r_last = 1'b0; cur_free = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_ar_valid", ar_valid, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);

        // T1: four full bursts, plus accept-to-AR latency
        start_xfer(32'h1000, 24'd512, 7'd64);
        check("t1_calc_no_ar", ar_valid, 0);
        @(negedge clk);
        check("t1_ar_at_t2", ar_valid, 1);
        run_until_done(100, 100, -1, cyc);

        // T2: 4KB crossing split
        start_xfer(32'h0FC0, 24'd256, 7'd64);
        run_until_done(100, 100, -1, cyc);

        // Address wrap at top of space
        start_xfer(32'hFFFF_FFC0, 24'd256, 7'd64);
        run_until_done(70, 60, -1, cyc);

        // T3: insufficient FIFO room holds issue
        start_xfer(32'h2000, 24'd128, 7'd10);
        repeat (5) begin
            @(negedge clk);
            check("t3_hold_low_room", ar_valid, 0);
        end
        fifo_free_cnt = 7'd16;
        cur_free = 7'd16;
        @(negedge clk);
        check("t3_ar_after_room", ar_valid, 1);
        run_until_done(100, 100, -1, cyc);

        // T4: AR stalled, outputs stable, then one handshake
        start_xfer(32'h3000, 24'd256, 7'd16);
        for (int i = 0; i < 10 && !ar_valid; i++) @(negedge clk);
        repeat (5) begin
            check("t4_valid", ar_valid, 1);
            check("t4_addr", ar_addr, 32'h3000);
            check("t4_len", ar_len, 15);
            @(negedge clk);
        end
        check("t4_rsv_before", u_dut.rsv, 0);
        ar_ready = 1'b1;
        rq.push_back(exp_b[0]);
        void'(exp_a.pop_front());
        void'(exp_b.pop_front());
        @(negedge clk);
        ar_ready = 1'b0;
        check("t4_rsv_after", u_dut.rsv, 16);
        check("t4_valid_drop", ar_valid, 0);
        run_until_done(100, 100, -1, cyc);

        // T5: zero length, then abort during a long transfer
        start_xfer(32'h0100, 24'd0, 7'd64);
        check("t5_no_ar", ar_valid, 0);
        run_until_done(100, 100, -1, cyc);
        check("t5_done_next_cycle", cyc, 0);
        start_xfer(32'h4000, 24'd1024, 7'd64);
        run_until_done(50, 80, 3, cyc);

        // T6: reset mid-transfer, then orphan beat sets err
        start_xfer(32'h5000, 24'd512, 7'd64);
        ar_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ar_ready = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_ar_valid", ar_valid, 0);
        check("t6_cfg_ready", cfg_ready, 1);
        check("t6_rsv", u_dut.rsv, 0);
        r_beat = 1'b1;
        r_last = 1'b1;
        @(negedge clk);
        r_beat = 1'b0;
        r_last = 1'b0;
        check("t6_err_set", err, 1);
        @(negedge clk);
        check("t6_err_sticky", err, 1);
        start_xfer(32'h6000, 24'd64, 7'd64);
        run_until_done(100, 100, -1, cyc);

        // Randomized descriptors
        for (int n = 0; n < 24; n++) begin
            tmp = $urandom;
            if (n % 3 == 0)
                a = {tmp[31:12], 12'(4096 - 8 * $urandom_range(1, 20))};
            else
                a = {tmp[31:3], 3'b000};
            start_xfer(a, 24'(8 * $urandom_range(0, 80)),
                       7'($urandom_range(16, 64)));
            run_until_done($urandom_range(30, 100), $urandom_range(30, 100),
                           (n % 4 == 1) ? int'($urandom_range(1, 20)) : -1, cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
